// File: rtl/intc_ctrl.sv
// ============================================================================
// Module      : intc_ctrl
// Description : Six-source interrupt controller between the bridge interrupt
//               lines and the CPU exception logic. Captures, masks and
//               prioritises the sources, then raises one IRQ with a vector.
//               Handshake: IntAck pulse from the CPU, then an EOI written to
//               the VEC register. Lowest index has the highest priority.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               HWIn[5:0]       - raw interrupt sources (bit i = HWInt[i+2])
//               IntAdd/IntWe/IntWD/IntRD - word-addressed register port
//                                 (00 PEND, 01 MASK, 10 VEC, 11 CTRL)
//               IntAck          - CPU exception-entry pulse
//               IRQ, IntVec     - registered request and its source index
// Options     : define INTC_NESTED_EN to allow preemption of a source in
//               service by a higher-priority one (ISR holds several bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_ctrl #(
    parameter int              NSRC      = 6,
    parameter logic [NSRC-1:0] EDGE_MASK = 6'b000011
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] HWIn,
    input  logic [1:0]      IntAdd,
    input  logic            IntWe,
    input  logic [31:0]     IntWD,
    output logic [31:0]     IntRD,
    input  logic            IntAck,
    output logic            IRQ,
    output logic [2:0]      IntVec
);

    localparam logic [1:0] c_addr_pend = 2'd0;
    localparam logic [1:0] c_addr_mask = 2'd1;
    localparam logic [1:0] c_addr_vec  = 2'd2;
    localparam logic [1:0] c_addr_ctrl = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NSRC-1:0] r_hw_q;       // first sample of HWIn
    logic [NSRC-1:0] r_hw_d;       // previous sample, for edge detection
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_isr;
    logic            r_gie;
    logic            r_irq;
    logic [2:0]      r_vec;

    logic [NSRC-1:0] w_req_bits;
    logic            w_cand_valid;
    logic [2:0]      w_cand_idx;
    logic            w_isr_any;
    logic [2:0]      w_isr_lo;
    logic            w_preempt_ok;
    logic            w_eoi;
    logic            w_take_ack;
    logic [2:0]      w_ack_idx;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_isr_nxt;
    logic            w_unused_wd;

    assign w_unused_wd = ^IntWD[31:NSRC];

    assign w_req_bits = r_pend & r_mask;
    assign w_eoi      = IntWe && (IntAdd == c_addr_vec);
    assign w_w1c      = (IntWe && (IntAdd == c_addr_pend)) ? (IntWD[NSRC-1:0] & EDGE_MASK) : '0;
    assign w_rise     = r_hw_q & ~r_hw_d & EDGE_MASK;

    // Lowest-index pending & enabled source, and lowest-index in-service bit.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_idx   = '0;
        w_isr_any    = 1'b0;
        w_isr_lo     = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req_bits[i]) begin
                w_cand_valid = 1'b1;
                w_cand_idx   = 3'(i);
            end
            if (r_isr[i]) begin
                w_isr_any = 1'b1;
                w_isr_lo  = 3'(i);
            end
        end
    end

    // A candidate may be requested when it outranks everything in service.
    // ISR is always empty outside SERVICE in the non-nested build, so this
    // reduces to GIE & candidate there.
    assign w_preempt_ok = r_gie && w_cand_valid && (!w_isr_any || (w_cand_idx < w_isr_lo));

    // If the candidate vanished in the ack cycle, ack the vector the CPU saw.
    assign w_ack_idx = w_cand_valid ? w_cand_idx : r_vec;
    assign w_ack_clr = w_take_ack ? ((NSRC'(1) << w_ack_idx) & EDGE_MASK) : '0;

    // Set beats any clear in the same cycle; level bits just follow the sample.
    assign w_pend_nxt = (((r_pend & ~w_w1c & ~w_ack_clr) | w_rise) & EDGE_MASK)
                      | (r_hw_q & ~EDGE_MASK);

    always_comb begin
        w_state_nxt = r_state;
        w_take_ack  = 1'b0;
        w_isr_nxt   = r_isr;
        case (r_state)
            ST_IDLE: begin
                if (w_preempt_ok) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (IntAck) begin
                    w_state_nxt = ST_SERVICE;
                    w_take_ack  = 1'b1;
                    w_isr_nxt   = r_isr | (NSRC'(1) << w_ack_idx);
                end else if (!w_preempt_ok) begin
                    // Withdrawn request falls back to whatever was interrupted.
                    w_state_nxt = w_isr_any ? ST_SERVICE : ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_eoi) begin
`ifdef INTC_NESTED_EN
                    w_isr_nxt   = r_isr & ~(NSRC'(1) << w_isr_lo);
                    w_state_nxt = (|w_isr_nxt) ? ST_SERVICE : ST_IDLE;
`else
                    w_isr_nxt   = '0;
                    w_state_nxt = ST_IDLE;
`endif
                end
`ifdef INTC_NESTED_EN
                else if (w_preempt_ok) begin
                    w_state_nxt = ST_REQ;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hw_q  <= '0;
            r_hw_d  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_isr   <= '0;
            r_gie   <= 1'b0;
            r_irq   <= 1'b0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hw_q  <= HWIn;
            r_hw_d  <= r_hw_q;
            r_pend  <= w_pend_nxt;
            r_isr   <= w_isr_nxt;
            if (IntWe && (IntAdd == c_addr_mask)) begin
                r_mask <= IntWD[NSRC-1:0];
            end
            if (IntWe && (IntAdd == c_addr_ctrl)) begin
                r_gie <= IntWD[0];
            end
            r_irq <= (w_state_nxt == ST_REQ);
            r_vec <= (w_state_nxt == ST_REQ) ? w_cand_idx : 3'd0;
        end
    end

    assign IRQ    = r_irq;
    assign IntVec = r_vec;

    // The active source is the lowest set ISR bit; with nesting disabled ISR
    // holds exactly the acknowledged source while in service.
    always_comb begin
        IntRD = '0;
        case (IntAdd)
            c_addr_pend: IntRD = 32'(r_pend);
            c_addr_mask: IntRD = 32'(r_mask);
            c_addr_vec:  IntRD = {(r_state == ST_SERVICE), 28'b0, w_isr_lo};
            c_addr_ctrl: IntRD = (32'(EDGE_MASK) << 8) | 32'(r_gie);
            default:     IntRD = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_intc_ctrl.sv
// ============================================================================
// Module      : tb_intc_ctrl
// Description : Scoreboard bench for intc_ctrl. Stimulus pushes expected
//               observations into a queue; a monitor on the falling edge pops
//               and compares them against IRQ, IntVec or IntRD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  HWIn;
    logic [1:0]  IntAdd;
    logic        IntWe;
    logic [31:0] IntWD;
    logic [31:0] IntRD;
    logic        IntAck;
    logic        IRQ;
    logic [2:0]  IntVec;

    intc_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .HWIn   (HWIn),
        .IntAdd (IntAdd),
        .IntWe  (IntWe),
        .IntWD  (IntWD),
        .IntRD  (IntRD),
        .IntAck (IntAck),
        .IRQ    (IRQ),
        .IntVec (IntVec)
    );

    always #5 clk = ~clk;

    localparam int K_IRQ = 0;
    localparam int K_VEC = 1;
    localparam int K_RD  = 2;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Monitor: everything queued during a cycle is compared on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.kind)
                K_IRQ:   act = 32'(IRQ);
                K_VEC:   act = 32'(IntVec);
                default: act = IntRD;
            endcase
            n_chk++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] v, input string nm);
        chk_t c;
        c.kind = kind;
        c.exp  = v;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic exp_irq(input logic v, input string nm);
        push(K_IRQ, 32'(v), nm);
    endtask

    task automatic exp_vec(input logic [2:0] v, input string nm);
        push(K_VEC, 32'(v), nm);
    endtask

    task automatic exp_rd(input logic [1:0] a, input logic [31:0] v, input string nm);
        IntAdd = a;
        push(K_RD, v, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        IntAdd = a;
        IntWD  = d;
        IntWe  = 1'b1;
        tick();
        IntWe  = 1'b0;
        IntWD  = '0;
    endtask

    task automatic ack();
        IntAck = 1'b1;
        tick();
        IntAck = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        HWIn   = '0;
        IntAdd = '0;
        IntWe  = 1'b0;
        IntWD  = '0;
        IntAck = 1'b0;
        tick(2);

        // Reset state
        exp_irq(1'b0, "rst_irq");
        exp_vec(3'd0, "rst_vec");
        exp_rd(2'd0, 32'h0, "rst_pend");        tick();
        exp_rd(2'd1, 32'h0, "rst_mask");        tick();
        exp_rd(2'd2, 32'h0, "rst_vecreg");      tick();
        exp_rd(2'd3, 32'h0000_0300, "rst_ctrl"); tick();
        rst = 1'b0;
        tick();

        // Single edge source: IRQ exactly two edges after the sampling edge
        wr(2'd1, 32'h01);
        wr(2'd3, 32'h01);
        exp_rd(2'd3, 32'h0000_0301, "t1_ctrl_gie"); tick();
        HWIn = 6'h01;
        exp_irq(1'b0, "t1_irq_idle");     tick();
        HWIn = 6'h00;
        exp_irq(1'b0, "t1_irq_k");        tick();
        exp_irq(1'b0, "t1_irq_k1");
        exp_rd(2'd0, 32'h01, "t1_pend");  tick();
        exp_irq(1'b1, "t1_irq");
        exp_vec(3'd0, "t1_vec");
        ack();
        exp_irq(1'b0, "t1_ack_irq");
        exp_rd(2'd2, 32'h8000_0000, "t1_vec_service"); tick();
        exp_rd(2'd0, 32'h0, "t1_pend_clr"); tick();
        wr(2'd2, 32'h0);
        exp_irq(1'b0, "t1_eoi_irq");
        exp_rd(2'd2, 32'h0, "t1_eoi_vec"); tick();

        // Priority: level 4 first, edge 1 arrives a cycle later and replaces it
        wr(2'd1, 32'h3F);
        HWIn = 6'h10; tick();
        HWIn = 6'h12; tick();
        tick();
        exp_irq(1'b1, "t2_irq");
        exp_vec(3'd4, "t2_vec4");         tick();
        exp_irq(1'b1, "t2_irq_held");
        exp_vec(3'd1, "t2_vec1");
        ack();
        exp_irq(1'b0, "t2_ack_irq");
        exp_rd(2'd2, 32'h8000_0001, "t2_active1"); tick();
        wr(2'd2, 32'h0);
        exp_irq(1'b0, "t2_eoi_idle");     tick();
        exp_irq(1'b1, "t2_reassert");
        exp_vec(3'd4, "t2_vec4_again");   tick();
        HWIn = 6'h00;
        tick(4);
        exp_irq(1'b0, "t2_withdraw");     tick();

        // Masking and withdrawal
        wr(2'd1, 32'h00);
        HWIn = 6'h08;
        tick(3);
        exp_irq(1'b0, "t3_masked");
        exp_rd(2'd0, 32'h08, "t3_pend");  tick();
        wr(2'd1, 32'h08);
        tick();
        exp_irq(1'b1, "t3_unmask");
        exp_vec(3'd3, "t3_vec3");         tick();
        HWIn = 6'h00;
        tick(4);
        exp_irq(1'b0, "t3_withdraw");
        exp_rd(2'd0, 32'h0, "t3_pend_gone"); tick();

        // Write-1-to-clear collides with a new rising edge: set wins
        wr(2'd1, 32'h00);
        HWIn = 6'h01; tick();
        HWIn = 6'h00; tick(2);
        exp_rd(2'd0, 32'h01, "t4_pend_set"); tick();
        HWIn = 6'h01; tick();
        HWIn = 6'h00;
        wr(2'd0, 32'h01);
        exp_rd(2'd0, 32'h01, "t4_set_wins"); tick();
        wr(2'd0, 32'h01);
        exp_rd(2'd0, 32'h00, "t4_w1c");      tick();
        HWIn = 6'h04; tick(2);
        wr(2'd0, 32'h3F);
        exp_rd(2'd0, 32'h04, "t4_level_ignore"); tick();
        HWIn = 6'h00; tick(3);

        // Source 0 fires while source 3 is in service
        wr(2'd1, 32'h09);
        HWIn = 6'h08;
        tick(3);
        exp_irq(1'b1, "t5_irq3");
        exp_vec(3'd3, "t5_vec3");
        ack();
        HWIn = 6'h00;
        exp_irq(1'b0, "t5_service");
        exp_rd(2'd2, 32'h8000_0003, "t5_active3"); tick();
        HWIn = 6'h01; tick();
        HWIn = 6'h00; tick(2);
`ifdef INTC_NESTED_EN
        exp_irq(1'b1, "t5_preempt");
        exp_vec(3'd0, "t5_vec0");
        ack();
        exp_irq(1'b0, "t5_nest_irq");
        exp_rd(2'd2, 32'h8000_0000, "t5_nest_active0"); tick();
        wr(2'd2, 32'h0);
        exp_irq(1'b0, "t5_eoi1_irq");
        exp_rd(2'd2, 32'h8000_0003, "t5_eoi1_active3"); tick();
        wr(2'd2, 32'h0);
        exp_irq(1'b0, "t5_eoi2_irq");
        exp_rd(2'd2, 32'h0, "t5_eoi2_idle"); tick();
`else
        exp_irq(1'b0, "t5_no_preempt");
        exp_rd(2'd2, 32'h8000_0003, "t5_still3"); tick();
        exp_rd(2'd0, 32'h01, "t5_pend0");  tick();
        wr(2'd2, 32'h0);
        exp_irq(1'b0, "t5_eoi_idle");      tick();
        exp_irq(1'b1, "t5_after_eoi");
        exp_vec(3'd0, "t5_vec0");
        ack();
        exp_rd(2'd2, 32'h8000_0000, "t5_active0"); tick();
        wr(2'd2, 32'h0);
        exp_rd(2'd2, 32'h0, "t5_final_idle"); tick();
`endif

        tick(2);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            $fatal(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intc_ctrl.md
Name: intc_ctrl

Overview:
- Interrupt controller placed between the system bridge hardware-interrupt lines (HWInt[7:2]) and the CPU exception logic.
- Latches, masks and prioritises the six device interrupt sources, then drives one IRQ to the CPU with a vector, using an acknowledge / end-of-interrupt handshake.
- Software reaches its registers as a bridge-mapped device: 2-bit word address, write enable, 32-bit read/write data.

Parameters:
- NSRC, 6, number of interrupt sources. Bit i of HWIn corresponds to HWInt[i+2].
- EDGE_MASK, 6'b000011, per-source trigger mode: 1 = rising-edge latched, 0 = level.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- HWIn  input  6  raw interrupt sources from the bridge.
- IntAdd  input  2  register word address (PrAddr[3:2]).
- IntWe  input  1  register write strobe, one cycle per write.
- IntWD  input  32  register write data.
- IntRD  output  32  register read data, combinational from IntAdd.
- IntAck  input  1  CPU exception-entry pulse.
- IRQ  output  1  interrupt request to the CPU, registered.
- IntVec  output  3  index of the requested source, valid while IRQ=1.

Behaviour:
- Reset values: every register and output is 0. State = IDLE, PEND = 0, MASK = 0, GIE = 0, ISR = 0, edge-sample register = 0.
- Register map (by IntAdd):
  - 00 PEND: read {26'b0, PEND}. A write clears each edge-type bit where IntWD[i]=1 (write-1-to-clear). Level bits ignore writes.
  - 01 MASK: read/write, bits [5:0]. 1 = enabled.
  - 10 VEC: read {valid, 28'b0, active[2:0]}, where valid = (state == SERVICE). Any write is an EOI.
  - 11 CTRL: bit0 = GIE (read/write). Bits [13:8] read EDGE_MASK. All other bits read 0.
- Source capture:
  - Edge source: PEND[i] is set on the cycle after HWIn[i] is sampled 1 while the previous sample was 0.
  - Level source: PEND[i] = registered HWIn[i].
  - If a set and a w1c hit the same bit in the same cycle, set wins.
- Candidate = lowest index i with PEND[i] & MASK[i]. Index 0 has the highest priority.
- FSM:
  - IDLE: IRQ=0. If GIE and a candidate exists, go to REQ.
  - REQ: IRQ=1, IntVec = current candidate, re-evaluated every cycle so a newly arrived higher-priority source replaces it.
    - GIE cleared, or no candidate left (level source withdrawn or masked): return to IDLE; IRQ drops the next cycle.
    - IntAck=1: go to SERVICE. active <= candidate, ISR[active] <= 1, edge-type PEND[active] cleared. IntAck takes precedence over withdrawal in the same cycle.
  - SERVICE: IRQ=0. Wait for an EOI write; on EOI, ISR <= 0 and go to IDLE.
- Ignored events:
  - IntAck in IDLE or SERVICE.
  - EOI write outside SERVICE.
  - Source activity during SERVICE only updates PEND.
- Latency: HWIn sampled 1 at edge k gives PEND=1 after edge k+1 and IRQ=1 after edge k+2.
- Back-to-back: after EOI the FSM passes through IDLE for one cycle, so IRQ reasserts 2 cycles after the EOI write if anything is still pending.
- rst in any state returns to the reset values on the next edge, including dropping IRQ and clearing ISR.

Optional Feature:
- Macro name: INTC_NESTED_EN.
- Defined:
  - In SERVICE, a candidate with index lower than every set ISR bit moves the FSM to REQ (preemption).
  - ISR can hold multiple bits.
  - EOI clears only the lowest-index ISR bit. The FSM returns to SERVICE if any ISR bit remains set, otherwise to IDLE.
  - VEC.active reports the lowest-index set ISR bit.
- Undefined: no preemption, at most one ISR bit set, behaviour exactly as above.

Test Plan:
- Reset: assert rst 2 cycles → IRQ=0, IntVec=0, IntRD=0 for every IntAdd value, CTRL reads 0x0300.
- Single edge source: MASK=0x01, GIE=1, pulse HWIn[0] for 1 cycle → IRQ=1 exactly 2 cycles later with IntVec=0. IntAck → IRQ=0, VEC reads 0x80000000, PEND=0. EOI → IDLE.
- Priority: HWIn[4] (level) high, then 1 cycle later HWIn[1] edge, MASK=0x3F, GIE=1 → IRQ held with IntVec changing 4→1. Ack → active=1. EOI → IRQ reasserts 2 cycles later with IntVec=4.
- Masking and withdrawal: MASK=0x00 with HWIn[3] high → IRQ stays 0 while PEND=0x08. Set MASK=0x08 → IRQ=1. Drop HWIn[3] before ack → IRQ returns to 0.
- w1c collision: PEND[0] set, then write PEND=0x01 in the same cycle as a new HWIn[0] rising edge → PEND[0] stays 1. Separate w1c write → PEND[0]=0.
- Nested (INTC_NESTED_EN): in SERVICE of source 3, fire source 0 → IRQ=1 with IntVec=0. Ack → ISR=0x09. First EOI → VEC.active=3, IRQ=0. Second EOI → IDLE. Without the macro, IRQ stays 0 until the first EOI.
